alu_cmd_ctrl: RTL

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

---
 rtl/alu_cmd_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_ctrl.sv
// Command/response sequencer wrapped around an external combinational 8-bit ALU.
// It registers the ALU operands and holds them steady while the ALU settles.
// It then captures the ALU result into a response, which is held until the
// consumer accepts it. The low byte of each result is kept in an accumulator
// that a later command can use as operand A.
module alu_cmd_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_sel,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_use_acc,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [3:0]  alu_sel,
  input  logic [15:0] alu_Y,
  input  logic        alu_Z,
  input  logic        alu_N,
  input  logic        alu_C,
  input  logic        alu_V,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_y,
  output logic [3:0]  rsp_flags,
  output logic        rsp_illegal,
  output logic [15:0] op_count
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned RES_W   = 16;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned SEL_MAX = 9;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
  logic [RES_W-1:0]    rsp_y_q, rsp_y_d;
  logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
  logic                rsp_illegal_q, rsp_illegal_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [RES_W-1:0]    op_count_q, op_count_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                launch_q, launch_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= '0;
      rsp_y_q       <= '0;
      rsp_flags_q   <= '0;
      rsp_illegal_q <= 1'b0;
      acc_q         <= '0;
      op_count_q    <= '0;
      cnt_q         <= '0;
      launch_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      rsp_y_q       <= rsp_y_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_illegal_q <= rsp_illegal_d;
      acc_q         <= acc_d;
      op_count_q    <= op_count_d;
      cnt_q         <= cnt_d;
      launch_q      <= launch_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end

  // Next-state logic: accept, then settle, then capture, then hand off.
  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_sel_d     = alu_sel_q;
    rsp_y_d       = rsp_y_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_illegal_d = rsp_illegal_q;
    acc_d         = acc_q;
    op_count_d    = op_count_q;
    cnt_d         = cnt_q;
    launch_d      = launch_q;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_a_d   = cmd_use_acc ? acc_q : cmd_a;
          alu_b_d   = cmd_b;
          alu_sel_d = cmd_sel;
          cnt_d     = CNT_LOAD;
          launch_d  = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // The first EXEC cycle launches the new operands; the settle count
        // starts after that.
        if (launch_q) begin
          launch_d = 1'b0;
        end else if (cnt_q == '0) begin
          rsp_y_d       = alu_Y;
          rsp_flags_d   = {alu_Z, alu_N, alu_C, alu_V};
          rsp_illegal_d = (alu_sel_q > SEL_W'(SEL_MAX));
          acc_d         = alu_Y[DATA_W-1:0];
          state_d       = RESP;
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = RES_W'(op_count_q + 1'b1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign alu_A       = alu_a_q;
  assign alu_B       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_illegal = rsp_illegal_q;
  assign op_count    = op_count_q;

endmodule
